// File: rtl/timed_seq_pkg.sv
// Shared types and helpers for the timed four-state sequencer.
// State encoding doubles as the 2-bit state output.
package timed_seq_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_WAIT = 2'b01,
    S_RUN  = 2'b10,
    S_DONE = 2'b11
  } state_t;

  // A dwell of N cycles loads N-1 so the state exits on the cycle after the count reads zero.
  function automatic int dwell_load(input int cyc);
    return cyc - 1;
  endfunction

  function automatic bit cyc_legal(input int cyc, input int cnt_w);
    return (cyc >= 1) && (longint'(cyc) < (longint'(1) << cnt_w));
  endfunction

endpackage

// File: rtl/timed_seq_dwell_timer.sv
// Loadable down-counter that measures how long the sequencer stays in a state.
// Clear wins over load; the count saturates at zero.
module dwell_timer #(
  parameter int CNT_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_clr,
  output logic             o_zero
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/timed_seq_fsm.sv
// Four-state IDLE/WAIT/RUN/DONE sequencer with per-state dwell timing, abort,
// back-to-back restart, a first-DONE-cycle pulse and a wrapping sequence counter.
module timed_seq_fsm
  import timed_seq_pkg::*;
#(
  parameter int WAIT_CYC = 4,
  parameter int RUN_CYC  = 2,
  parameter int DONE_CYC = 1,
  parameter int CNT_W    = 8,
  parameter int EXT_T_EN = 0,
  parameter int SEQ_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             x,
  input  logic             t,
  input  logic             abort,
  output logic [1:0]       out,
  output logic             busy,
  output logic             done,
  output logic [SEQ_W-1:0] seq_cnt
);

  localparam logic [CNT_W-1:0] WAIT_LD = CNT_W'(dwell_load(WAIT_CYC));
  localparam logic [CNT_W-1:0] RUN_LD  = CNT_W'(dwell_load(RUN_CYC));
  localparam logic [CNT_W-1:0] DONE_LD = CNT_W'(dwell_load(DONE_CYC));

  if (!cyc_legal(WAIT_CYC, CNT_W)) begin : g_bad_wait
    $error("timed_seq_fsm: WAIT_CYC=%0d outside 1..2^CNT_W-1", WAIT_CYC);
  end
  if (!cyc_legal(RUN_CYC, CNT_W)) begin : g_bad_run
    $error("timed_seq_fsm: RUN_CYC=%0d outside 1..2^CNT_W-1", RUN_CYC);
  end
  if (!cyc_legal(DONE_CYC, CNT_W)) begin : g_bad_done
    $error("timed_seq_fsm: DONE_CYC=%0d outside 1..2^CNT_W-1", DONE_CYC);
  end
  if (EXT_T_EN != 0 && EXT_T_EN != 1) begin : g_bad_ext
    $error("timed_seq_fsm: EXT_T_EN=%0d must be 0 or 1", EXT_T_EN);
  end

  state_t           r_state;
  state_t           w_next;
  logic             w_load;
  logic [CNT_W-1:0] w_load_val;
  logic             w_clr;
  logic             w_zero;
  logic             w_wait_exit;
  logic             w_enter_done;
  logic             r_done;
  logic [SEQ_W-1:0] r_seq_cnt;

  dwell_timer #(.CNT_W(CNT_W)) u_dwell (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .i_clr      (w_clr),
    .o_zero     (w_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // In external mode WAIT ignores the timer and leaves only on t.
  assign w_wait_exit = (EXT_T_EN != 0) ? t : w_zero;

  always_comb begin
    w_next     = r_state;
    w_load     = 1'b0;
    w_load_val = '0;
    w_clr      = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (!x) begin
          w_next     = S_WAIT;
          w_load     = 1'b1;
          w_load_val = WAIT_LD;
        end
      end
      S_WAIT: begin
        if (abort) begin
          w_next = S_IDLE;
          w_clr  = 1'b1;
        end else if (w_wait_exit) begin
          w_next     = S_RUN;
          w_load     = 1'b1;
          w_load_val = RUN_LD;
        end
      end
      S_RUN: begin
        if (abort) begin
          w_next = S_IDLE;
          w_clr  = 1'b1;
        end else if (w_zero) begin
          w_next     = S_DONE;
          w_load     = 1'b1;
          w_load_val = DONE_LD;
        end
      end
      S_DONE: begin
        if (abort) begin
          w_next = S_IDLE;
          w_clr  = 1'b1;
        end else if (w_zero) begin
          if (!x) begin
            w_next     = S_WAIT;
            w_load     = 1'b1;
            w_load_val = WAIT_LD;
          end else begin
            w_next = S_IDLE;
          end
        end
      end
    endcase
  end

  assign w_enter_done = (w_next == S_DONE) && (r_state != S_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_done    <= 1'b0;
      r_seq_cnt <= '0;
    end else begin
      r_done <= w_enter_done;
      if (w_enter_done) begin
        r_seq_cnt <= r_seq_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    out     = r_state;
    busy    = (r_state != S_IDLE);
    done    = r_done;
    seq_cnt = r_seq_cnt;
  end

endmodule

// File: tb/tb_timed_seq_fsm.sv
// Three differently parameterised sequencers share one random stimulus stream;
// a schedule-queue reference model feeds per-DUT scoreboards checked on the falling edge.
module tb_timed_seq_fsm;

  logic clk;
  logic rst_n;
  logic x;
  logic t;
  logic abort;

  logic [1:0] out_a, out_b, out_c;
  logic       busy_a, busy_b, busy_c;
  logic       done_a, done_b, done_c;
  logic [7:0] seq_a, seq_b;
  logic [1:0] seq_c;

  timed_seq_fsm #(.WAIT_CYC(4), .RUN_CYC(2), .DONE_CYC(1), .CNT_W(8), .EXT_T_EN(0), .SEQ_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .x(x), .t(t), .abort(abort),
    .out(out_a), .busy(busy_a), .done(done_a), .seq_cnt(seq_a)
  );
  timed_seq_fsm #(.WAIT_CYC(4), .RUN_CYC(2), .DONE_CYC(3), .CNT_W(8), .EXT_T_EN(1), .SEQ_W(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .x(x), .t(t), .abort(abort),
    .out(out_b), .busy(busy_b), .done(done_b), .seq_cnt(seq_b)
  );
  timed_seq_fsm #(.WAIT_CYC(1), .RUN_CYC(2), .DONE_CYC(1), .CNT_W(4), .EXT_T_EN(0), .SEQ_W(2)) dut_c (
    .clk(clk), .rst_n(rst_n), .x(x), .t(t), .abort(abort),
    .out(out_c), .busy(busy_c), .done(done_c), .seq_cnt(seq_c)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int WAITC[3] = '{4, 4, 1};
  int RUNC[3]  = '{2, 2, 2};
  int DONEC[3] = '{1, 3, 1};
  int EXTC[3]  = '{0, 1, 0};
  int SEQM[3]  = '{255, 255, 3};

  typedef struct {
    int out;
    int done;
    int seq;
  } exp_t;

  // Schedule of upcoming state outputs, one entry per cycle; 5 = WAIT until t.
  int   sched[3][$];
  int   mseq[3];
  exp_t expq[3][$];

  int n_assert = 0;
  int n_fail   = 0;
  int cycle    = 0;

  task automatic chk(input string name, input int k, input int act, input int exp);
    n_assert++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s dut%0d cycle %0d: got %0d, required %0d", name, k, cycle, act, exp);
    end
  endtask

  task automatic push_seq(input int k);
    if (EXTC[k] != 0) sched[k].push_back(5);
    else for (int i = 0; i < WAITC[k]; i++) sched[k].push_back(1);
    for (int i = 0; i < RUNC[k]; i++) sched[k].push_back(2);
    for (int i = 0; i < DONEC[k]; i++) sched[k].push_back(3);
  endtask

  // Reference model: advance each schedule by one clock using the sampled inputs.
  initial begin
    for (int k = 0; k < 3; k++) mseq[k] = 0;
    forever begin
      @(posedge clk);
      cycle++;
      for (int k = 0; k < 3; k++) begin
        int   old_f;
        int   new_f;
        exp_t e;
        old_f = (sched[k].size() != 0) ? sched[k][0] : 0;
        if (!rst_n) begin
          sched[k].delete();
          mseq[k] = 0;
        end else if (sched[k].size() == 0) begin
          if (!x) push_seq(k);
        end else if (abort) begin
          sched[k].delete();
        end else if (sched[k][0] == 5) begin
          if (t) void'(sched[k].pop_front());
        end else if (sched[k][0] == 3 && sched[k].size() == 1) begin
          void'(sched[k].pop_front());
          if (!x) push_seq(k);
        end else begin
          void'(sched[k].pop_front());
        end
        new_f = (sched[k].size() != 0) ? sched[k][0] : 0;
        e.done = (old_f == 2 && new_f == 3) ? 1 : 0;
        if (e.done != 0) mseq[k] = (mseq[k] + 1) & SEQM[k];
        e.out = (new_f == 5) ? 1 : new_f;
        e.seq = mseq[k];
        expq[k].push_back(e);
      end
    end
  end

  logic [1:0] a_out[3];
  logic       a_busy[3];
  logic       a_done[3];
  logic [7:0] a_seq[3];
  assign a_out[0] = out_a;  assign a_out[1] = out_b;  assign a_out[2] = out_c;
  assign a_busy[0] = busy_a; assign a_busy[1] = busy_b; assign a_busy[2] = busy_c;
  assign a_done[0] = done_a; assign a_done[1] = done_b; assign a_done[2] = done_c;
  assign a_seq[0] = seq_a;  assign a_seq[1] = seq_b;  assign a_seq[2] = {6'b0, seq_c};

  // Monitor: pop one expectation per DUT per cycle and compare.
  initial begin
    forever begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        if (expq[k].size() == 0) begin
          chk("scoreboard_empty", k, 0, 1);
        end else begin
          exp_t e;
          e = expq[k].pop_front();
          chk("out", k, int'(a_out[k]), e.out);
          chk("busy", k, int'(a_busy[k]), (e.out != 0) ? 1 : 0);
          chk("done", k, int'(a_done[k]), e.done);
          chk("seq_cnt", k, int'(a_seq[k]), e.seq);
          if (e.done != 0)
            $display("dut%0d cycle %0d: sequence complete, seq_cnt=%0d", k, cycle, e.seq);
        end
      end
    end
  end

  task automatic step(input logic nx, input logic nt, input logic nab, input logic nrst);
    @(negedge clk);
    #1;
    x = nx; t = nt; abort = nab; rst_n = nrst;
  endtask

  task automatic wait_run_a(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 30 && !ok; i++) begin
      @(negedge clk);
      if (out_a == 2'b10) ok = 1'b1;
    end
    if (!ok) chk("wait_run_timeout", 0, 0, 1);
  endtask

  initial begin
    bit ok;
    rst_n = 1'b0; x = 1'b1; t = 1'b0; abort = 1'b0;
    repeat (3) step(1, 0, 0, 0);
    repeat (10) step(1, 0, 0, 1);
    // single start pulse; the external-t DUT stays in WAIT until t
    step(0, 0, 0, 1);
    repeat (20) step(1, 0, 0, 1);
    step(1, 1, 0, 1);
    repeat (12) step(1, 0, 0, 1);
    // continuous start request: back-to-back sequences
    repeat (40) step(0, 1, 0, 1);
    repeat (12) step(1, 0, 0, 1);
    // abort during the first RUN cycle
    step(0, 1, 0, 1);
    step(1, 1, 0, 1);
    wait_run_a(ok);
    #1 abort = 1'b1;
    step(1, 0, 0, 1);
    repeat (12) step(1, 0, 0, 1);
    // abort on the RUN->DONE edge
    step(0, 1, 0, 1);
    step(1, 1, 0, 1);
    wait_run_a(ok);
    step(1, 1, 1, 1);
    repeat (12) step(1, 0, 0, 1);
    // asynchronous reset mid-WAIT after some completed sequences
    repeat (2) step(0, 0, 0, 1);
    step(1, 0, 0, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_async_out", 0, int'(out_a), 0);
    chk("rst_async_seq", 0, int'(seq_a), 0);
    chk("rst_async_out", 1, int'(out_b), 0);
    chk("rst_async_done", 2, int'(done_c), 0);
    repeat (10) step(1, 0, 0, 1);
    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic rx, rt, rab, rr;
      rx  = ($urandom_range(0, 2) != 0);
      rt  = ($urandom_range(0, 3) == 0);
      rab = ($urandom_range(0, 19) == 0);
      rr  = ($urandom_range(0, 299) != 0);
      step(rx, rt, rab, rr);
    end
    repeat (5) step(1, 0, 0, 1);
    @(negedge clk);
    #2;
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/timed_seq_fsm.md
Name: timed_seq_fsm

Overview:
Parametrised four-state sequencer (IDLE, WAIT, RUN, DONE) with a 2-bit state output. It is the next generation of the team's X/T-driven 2-bit controller. Each state's dwell time comes from an internal down-counter; an optional mode exits WAIT on the external t input instead. Adds synchronous abort, back-to-back restart, a completion pulse and a wrapping sequence counter. Used as the control-path sequencer in the lab datapath builds.

Parameters:
WAIT_CYC, 4, cycles spent in WAIT (internal-timer mode); legal range 1..2^CNT_W-1
RUN_CYC, 2, cycles spent in RUN; legal range 1..2^CNT_W-1
DONE_CYC, 1, cycles spent in DONE; legal range 1..2^CNT_W-1
CNT_W, 8, width of the dwell down-counter
EXT_T_EN, 0, 1 = WAIT exits on t==1 and ignores WAIT_CYC; 0 = WAIT exits on timer expiry
SEQ_W, 8, width of the completed-sequence counter

Ports:
clk  in  1  clock; all state changes on posedge
rst_n  in  1  asynchronous, active-low reset
x  in  1  start request, active low; sampled only in IDLE and on the last DONE cycle
t  in  1  WAIT exit qualifier; used only when EXT_T_EN=1
abort  in  1  synchronous abort, active high
out  out  2  current state: 00 IDLE, 01 WAIT, 10 RUN, 11 DONE
busy  out  1  1 whenever out != 00
done  out  1  one-cycle pulse, high in the first cycle of DONE
seq_cnt  out  SEQ_W  count of sequences that reached DONE

Behaviour:
- Reset: asynchronous, active low. While rst_n=0: out=00, busy=0, done=0, seq_cnt=0, dwell counter=0. The first posedge after deassertion evaluates from IDLE.
- All outputs are registered or decoded directly from registers. x, t and abort are treated as already synchronous to clk.
- Dwell counter: loaded with N-1 on entry to a timed state; decrements each cycle; the state exits on the cycle after it reads 0. A state with N=1 therefore lasts exactly 1 cycle.
- IDLE: x==0 -> WAIT and load WAIT_CYC-1; otherwise stay. abort has no effect.
- WAIT, EXT_T_EN=0: after exactly WAIT_CYC cycles -> RUN, load RUN_CYC-1.
- WAIT, EXT_T_EN=1: t==1 at a posedge -> RUN; otherwise stay indefinitely. The counter is unused.
- RUN: after exactly RUN_CYC cycles -> DONE, load DONE_CYC-1.
- DONE: after exactly DONE_CYC cycles, at the final-cycle posedge:
  - x==0 -> WAIT (back-to-back restart, no IDLE cycle)
  - otherwise -> IDLE
- done: set in the first DONE cycle only, even when DONE_CYC>1.
- seq_cnt: increments by 1 on each entry to DONE and wraps from 2^SEQ_W-1 to 0.
- abort: highest priority in WAIT, RUN and DONE. Next state is IDLE and the counter is cleared. An aborted sequence gets no done pulse and no seq_cnt increment. An abort in the same cycle as RUN->DONE also wins, so DONE is never entered.
- Simultaneous abort=1 and x=0 on the last DONE cycle: abort wins and the next state is IDLE.
- Reset mid-sequence: immediate return to IDLE. seq_cnt is cleared.
- Elaboration: illegal parameter values (0 or >= 2^CNT_W) must be rejected by an initial check that raises $error.

Decomposition:
- Shared package timed_seq_pkg:
  - state type with S_IDLE=2'b00, S_WAIT=2'b01, S_RUN=2'b10, S_DONE=2'b11
  - a localparam helper for the counter load values
- One natural sub-module, dwell_timer: CNT_W-bit loadable down-counter with load, load_val, clr and a zero flag.
- The FSM, done pulse and seq_cnt stay in the top module.

Test Plan:
- Defaults, hold x=1 for 10 cycles -> out stays 00, busy=0. Pulse x=0 for one cycle -> out sequence 01×4, 10×2, 11×1, 00; done high exactly once; seq_cnt=1.
- EXT_T_EN=1: start, hold t=0 for 20 cycles -> out stays 01. Assert t=1 for one cycle -> next out=10, then RUN/DONE timing as above.
- x held low continuously with defaults -> DONE goes straight to WAIT, no 00 cycle. After 3 sequences seq_cnt=3 and 3 done pulses.
- Abort during RUN cycle 1 -> next out=00, done never asserts, seq_cnt unchanged. Abort on the RUN->DONE edge -> out=00, no DONE.
- rst_n low for 1 cycle mid-WAIT -> out=00 and seq_cnt=0 immediately, without waiting for a clock edge. After release with x=1 -> remains IDLE.
- SEQ_W=2, x held low for 5 sequences -> seq_cnt counts 1,2,3,0,1. DONE_CYC=3 -> done is high only in the first of the 3 DONE cycles.
